screen_arbiter: RTL and testbench
=================================

SCREEN_ARBITER -- requirements
Module: screen_arbiter

Interface
REQ-001 Parameter DWELL, default 100000000, display hold time in clock cycles per grant; legal range 2..2^32-1.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  [3:0]  per-requester display request, level-sensitive.
REQ-005 req_en  input  [3:0][7:0]  per-requester digit enable mask.
REQ-006 req_display  input  [3:0][7:0][3:0]  per-requester hex nibble per digit.
REQ-007 req_dots  input  [3:0][7:0]  per-requester decimal-point mask.
REQ-008 grant  output  [3:0]  one-hot owner of the screen; all-zero when idle.
REQ-009 done  output  [3:0]  one-cycle pulse to the owner on dwell expiry.
REQ-010 busy  output  1  high while any grant is active.
REQ-011 scr_en  output  [7:0]  digit enables to the 8-digit numeric screen.
REQ-012 scr_display  output  [7:0][3:0]  nibbles to the numeric screen.
REQ-013 scr_dots  output  [7:0]  dot mask to the numeric screen.

Function
REQ-014 Two states: IDLE (no owner) and SHOW (one owner, dwell counter running).
REQ-015 Arbitration is round-robin: search starts at index (last+1) mod 4 and wraps; the first asserted req wins.
REQ-016 `last` holds the most recently granted index; only an actual grant updates it.
REQ-017 IDLE with req != 0: at the next edge, grant becomes one-hot of the winner, busy=1, counter=DWELL-1, state=SHOW.
REQ-018 IDLE with req == 0: stay IDLE, grant=0, busy=0.
REQ-019 In SHOW, each cycle registers scr_en/scr_display/scr_dots from the owner's req_* inputs, one cycle latency; data tracks owner live.
REQ-020 In IDLE, scr_en=0, scr_display=0, scr_dots=0 (screen blank).
REQ-021 In SHOW, counter decrements by 1 per cycle while owner req stays high.
REQ-022 Counter==0 in SHOW with owner req high: done[owner]=1 for the next cycle and arbitration runs in the same cycle.
REQ-023 Dwell expiry arbitration: a winner (possibly the same owner if no other req is high) is granted the next cycle with counter=DWELL-1 and no idle gap; no request -> IDLE.
REQ-024 Owner deasserts req mid-dwell (counter>0): abort; no done pulse; arbitration runs the same cycle per REQ-023 excluding the owner.
REQ-025 Owner deasserts req in the same cycle counter==0: treated as abort (REQ-024); done not pulsed.
REQ-026 A full dwell of one grant is exactly DWELL cycles from grant rising to handover edge.
REQ-027 grant is always zero or one-hot; done is only ever set on the bit that was granted in the preceding cycle.
REQ-028 Non-owner req changes never disturb the current dwell; requesters are never preempted.
REQ-029 Counter width is $clog2(DWELL) bits; no wrap below zero is ever reached.

Reset
REQ-030 While rst=0: state=IDLE, grant=0, done=0, busy=0, scr_en=0, scr_display=0, scr_dots=0, counter=0, last=3 (requester 0 has first priority).
REQ-031 rst assertion mid-SHOW aborts immediately, asynchronously, without a done pulse; first arbitration after release occurs on the first rising edge with rst=1.

Verification (DWELL=4)
REQ-032 Reset, then req=4'b0001 held -> grant=0001 one cycle later, done[0] pulses every 4 cycles, scr_* equal req_*[0] delayed 1 cycle.
REQ-033 req=4'b1111 held from reset -> grant sequence 0001,0010,0100,1000,0001, each 4 cycles, back-to-back, done pulse at each handover.
REQ-034 Owner 2 granted, req[2] dropped after 2 cycles with req[3]=1 -> grant=1000 next cycle, done stays 0.
REQ-035 Grant to 1, req[1] dropped exactly when counter==0, req=0 otherwise -> IDLE, done=0, scr_en=0 next cycle.
REQ-036 rst pulsed low mid-dwell of owner 3 -> grant/scr_en/busy 0 immediately; after release with req=4'b1001, grant=0001 first.
REQ-037 Change req_display[owner] mid-dwell to 32'h12345678 -> scr_display follows one cycle later, counter unaffected.

Source files
------------

// File: rtl/screen_arbiter.sv
// Round-robin arbiter that lends an 8-digit numeric screen to one of four requesters
// for a fixed dwell time, mirroring the owner's digit data onto the screen.
module screen_arbiter #(
  parameter int unsigned DWELL = 100000000
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0][7:0]       req_en,
  input  logic [3:0][7:0][3:0]  req_display,
  input  logic [3:0][7:0]       req_dots,
  output logic [3:0]            grant,
  output logic [3:0]            done,
  output logic                  busy,
  output logic [7:0]            scr_en,
  output logic [7:0][3:0]       scr_display,
  output logic [7:0]            scr_dots
);

  localparam int unsigned      CntW    = $clog2(DWELL);
  localparam logic [CntW-1:0]  CntLoad = CntW'(DWELL - 1);

  typedef enum logic {
    StIdle,
    StShow
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          done_q, done_d;
  logic [7:0]          scr_en_q, scr_en_d;
  logic [7:0][3:0]     scr_display_q, scr_display_d;
  logic [7:0]          scr_dots_q, scr_dots_d;

  logic                rearb;
  logic                win_valid;
  logic [1:0]          win;
  logic [1:0]          idx;

  // Search starts one past the last grant; i == 4 wraps back onto last itself.
  always_comb begin
    win_valid = 1'b0;
    win       = last_q;
    idx       = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = '0;
    rearb   = 1'b0;

    case (state_q)
      StIdle: begin
        rearb = |req;
      end
      StShow: begin
        if (!req[last_q]) begin
          // Owner withdrew: abort without a done pulse, even on the final cycle.
          rearb = 1'b1;
        end else if (cnt_q == '0) begin
          done_d[last_q] = 1'b1;
          rearb          = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rearb) begin
      if (win_valid) begin
        state_d = StShow;
        last_d  = win;
        grant_d = 4'b0001 << win;
        cnt_d   = CntLoad;
      end else begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    end
  end

  // Screen follows whoever owns it after this edge; blank when going idle.
  always_comb begin
    scr_en_d      = '0;
    scr_display_d = '0;
    scr_dots_d    = '0;
    if (state_d == StShow) begin
      scr_en_d      = req_en[last_d];
      scr_display_d = req_display[last_d];
      scr_dots_d    = req_dots[last_d];
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_q        <= 2'd3;
      grant_q       <= '0;
      done_q        <= '0;
      scr_en_q      <= '0;
      scr_display_q <= '0;
      scr_dots_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      scr_en_q      <= scr_en_d;
      scr_display_q <= scr_display_d;
      scr_dots_q    <= scr_dots_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = (state_q == StShow);
  assign scr_en      = scr_en_q;
  assign scr_display = scr_display_q;
  assign scr_dots    = scr_dots_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter with a short dwell of 4 cycles.
module tb_screen_arbiter;

  logic                 clock = 1'b0;
  logic                 rst = 1'b1;
  logic [3:0]           req = '0;
  logic [3:0][7:0]      req_en;
  logic [3:0][7:0][3:0] req_display;
  logic [3:0][7:0]      req_dots;
  logic [3:0]           grant;
  logic [3:0]           done;
  logic                 busy;
  logic [7:0]           scr_en;
  logic [7:0][3:0]      scr_display;
  logic [7:0]           scr_dots;

  int n_checks = 0;
  int n_fail   = 0;

  screen_arbiter #(.DWELL(4)) dut (
    .clock       (clock),
    .rst         (rst),
    .req         (req),
    .req_en      (req_en),
    .req_display (req_display),
    .req_dots    (req_dots),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .scr_en      (scr_en),
    .scr_display (scr_display),
    .scr_dots    (scr_dots)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called 1 time unit after an edge; the next rising edge is the first with rst high.
  task automatic do_reset();
    rst = 1'b0;
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done got %b want 0000", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (scr_en !== 8'h00) begin n_fail++; $display("FAIL reset_scr_en got %h want 00", scr_en); end
    n_checks++; if (scr_display !== 32'h0) begin n_fail++; $display("FAIL reset_scr_display got %h want 0", scr_display); end
    n_checks++; if (scr_dots !== 8'h00) begin n_fail++; $display("FAIL reset_scr_dots got %h want 00", scr_dots); end
    rst = 1'b1;
    step();
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL idle_grant got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    step();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", grant); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL single_done0 got %b want 0000", done); end
    n_checks++; if (scr_en !== 8'h81) begin n_fail++; $display("FAIL single_scr_en got %h want 81", scr_en); end
    n_checks++; if (scr_display !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL single_scr_display got %h want a0a0a0a0", scr_display); end
    n_checks++; if (scr_dots !== 8'h01) begin n_fail++; $display("FAIL single_scr_dots got %h want 01", scr_dots); end
    for (int c = 2; c <= 4; c++) begin
      step();
      n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL single_done_mid c=%0d got %b want 0000", c, done); end
      n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_hold c=%0d got %b want 0001", c, grant); end
    end
    step();
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done_pulse1 got %b want 0001", done); end
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_regrant got %b want 0001", grant); end
    step();
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL single_done_clear got %b want 0000", done); end
    req_display[0] = 32'h12345678;
    #1;
    n_checks++; if (scr_display !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL display_latency got %h want a0a0a0a0", scr_display); end
    step();
    n_checks++; if (scr_display !== 32'h12345678) begin n_fail++; $display("FAIL display_follow got %h want 12345678", scr_display); end
    step();
    step();
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done_pulse2 got %b want 0001", done); end
    req_display[0] = 32'hA0A0A0A0;
    req = 4'b0000;
    step();
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL drop_grant got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b want 0", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL drop_done got %b want 0000", done); end
    n_checks++; if (scr_en !== 8'h00) begin n_fail++; $display("FAIL drop_scr_en got %h want 00", scr_en); end
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    logic [3:0] ed;
    req = 4'b1111;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        eg = 4'(1 << (g % 4));
        ed = (c == 0 && g > 0) ? 4'(1 << ((g - 1) % 4)) : 4'b0000;
        n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL rot_grant g=%0d c=%0d got %b want %b", g, c, grant, eg); end
        n_checks++; if (done !== ed) begin n_fail++; $display("FAIL rot_done g=%0d c=%0d got %b want %b", g, c, done, ed); end
        n_checks++; if (scr_en !== req_en[g % 4]) begin n_fail++; $display("FAIL rot_scr_en g=%0d c=%0d got %h want %h", g, c, scr_en, req_en[g % 4]); end
      end
    end
  endtask

  task automatic test_abort();
    req = 4'b0100;
    do_reset();
    step();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL abort_first got %b want 0100", grant); end
    step();
    req = 4'b1000;
    step();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL abort_handover got %b want 1000", grant); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL abort_done got %b want 0000", done); end
    req = 4'b1111;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL nopreempt c=%0d got %b want 1000", c, grant); end
      n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL nopreempt_done c=%0d got %b want 0000", c, done); end
    end
    step();
    n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL owner3_done got %b want 1000", done); end
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant got %b want 0001", grant); end
  endtask

  task automatic test_expire_abort();
    req = 4'b0010;
    do_reset();
    step();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL exp_grant got %b want 0010", grant); end
    repeat (3) step();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL exp_hold got %b want 0010", grant); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL exp_done_early got %b want 0000", done); end
    req = 4'b0000;
    step();
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL exp_idle_grant got %b want 0000", grant); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL exp_no_done got %b want 0000", done); end
    n_checks++; if (scr_en !== 8'h00) begin n_fail++; $display("FAIL exp_scr_en got %h want 00", scr_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exp_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    do_reset();
    step();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rmid_grant got %b want 1000", grant); end
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL rmid_async_grant got %b want 0000", grant); end
    n_checks++; if (scr_en !== 8'h00) begin n_fail++; $display("FAIL rmid_async_scr_en got %h want 00", scr_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy got %b want 0", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rmid_async_done got %b want 0000", done); end
    req = 4'b1001;
    #2;
    rst = 1'b1;
    step();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rmid_release_grant got %b want 0001", grant); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_release_busy got %b want 1", busy); end
    n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rmid_release_done got %b want 0000", done); end
  endtask

  initial begin
    req_en[0] = 8'h81;  req_en[1] = 8'h42;  req_en[2] = 8'h24;  req_en[3] = 8'h18;
    req_display[0] = 32'hA0A0A0A0;  req_display[1] = 32'hB1B1B1B1;
    req_display[2] = 32'hC2C2C2C2;  req_display[3] = 32'hD3D3D3D3;
    req_dots[0] = 8'h01;  req_dots[1] = 8'h02;  req_dots[2] = 8'h04;  req_dots[3] = 8'h08;

    test_reset();
    test_single();
    test_rotation();
    test_abort();
    test_expire_abort();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
